// File: rtl/reg_file_multiport.sv
// Multi-port register file: two read ports, two write ports, optional zero register,
// write-through bypass, optional registered reads and a per-register busy scoreboard.
module reg_file_multiport #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned DEPTH        = 16,
  parameter bit          ZERO_REG     = 1'b1,
  parameter bit          BYPASS       = 1'b1,
  parameter bit          READ_REG     = 1'b0,
  parameter int unsigned CPU_OUT_ADDR = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  input  logic [ADDR_W-1:0] WA1,
  input  logic [WIDTH-1:0]  data_in1,
  input  logic              write_enable1,
  input  logic [ADDR_W-1:0] WA2,
  input  logic [WIDTH-1:0]  data_in2,
  input  logic              write_enable2,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [WIDTH-1:0]  data_out1,
  output logic [WIDTH-1:0]  data_out2,
  output logic              busy1,
  output logic              busy2,
  output logic [WIDTH-1:0]  cpu_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic             wv1;
  logic             wv2;
  logic             cv;
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;

  // An address is usable when it is in range and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (int'(a) < int'(DEPTH)) && !(ZERO_REG && (a == '0));
  endfunction

  assign wv1 = write_enable1 && addr_ok(WA1);
  assign wv2 = write_enable2 && addr_ok(WA2);
  assign cv  = claim_en && addr_ok(claim_addr);

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mem_d[i]  = mem_q[i];
      busy_d[i] = busy_q[i];
      if (wv1 && (WA1 == ADDR_W'(i))) begin
        mem_d[i]  = data_in1;
        busy_d[i] = 1'b0;
      end
      // Port 2 is applied last so it wins a same-address collision.
      if (wv2 && (WA2 == ADDR_W'(i))) begin
        mem_d[i]  = data_in2;
        busy_d[i] = 1'b0;
      end
      // A new claim overrides the clear from a write retiring the same register.
      if (cv && (claim_addr == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  function automatic logic [WIDTH-1:0] read_val(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_ok(a)) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (a == ADDR_W'(i)) v = mem_q[i];
      end
      if (BYPASS) begin
        if (wv1 && (WA1 == a)) v = data_in1;
        if (wv2 && (WA2 == a)) v = data_in2;
      end
    end
    return v;
  endfunction

  function automatic logic busy_val(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    if (addr_ok(a)) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (a == ADDR_W'(i)) b = busy_q[i];
      end
    end
    return b;
  endfunction

  always_comb begin
    rd1_c = read_val(RA1);
    rd2_c = read_val(RA2);
    busy1 = busy_val(RA1);
    busy2 = busy_val(RA2);
  end

  generate
    if (READ_REG) begin : g_read_reg
      logic [WIDTH-1:0] dout1_q;
      logic [WIDTH-1:0] dout2_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          dout1_q <= '0;
          dout2_q <= '0;
        end else begin
          dout1_q <= rd1_c;
          dout2_q <= rd2_c;
        end
      end
      assign data_out1 = dout1_q;
      assign data_out2 = dout2_q;
    end else begin : g_read_comb
      assign data_out1 = rd1_c;
      assign data_out2 = rd2_c;
    end

    if (CPU_OUT_ADDR < DEPTH) begin : g_cpu_out
      assign cpu_out = mem_q[CPU_OUT_ADDR];
    end else begin : g_cpu_out_none
      assign cpu_out = '0;
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: table-driven checks on a combinational-read instance
// plus a queue-scoreboarded registered-read instance fed with the same stimulus.
module tb_reg_file_multiport;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] RA1, RA2, WA1, WA2, claim_addr;
  logic [7:0] data_in1, data_in2;
  logic       write_enable1, write_enable2, claim_en;

  logic [7:0] dout1, dout2, cpu;
  logic       b1, b2;
  logic [7:0] rr_dout1, rr_dout2, rr_cpu;
  logic       rr_b1, rr_b2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_multiport u_dut (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2),
    .WA1(WA1), .data_in1(data_in1), .write_enable1(write_enable1),
    .WA2(WA2), .data_in2(data_in2), .write_enable2(write_enable2),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .data_out1(dout1), .data_out2(dout2), .busy1(b1), .busy2(b2), .cpu_out(cpu)
  );

  reg_file_multiport #(.READ_REG(1'b1)) u_dut_rr (
    .clk(clk), .reset(reset), .RA1(RA1), .RA2(RA2),
    .WA1(WA1), .data_in1(data_in1), .write_enable1(write_enable1),
    .WA2(WA2), .data_in2(data_in2), .write_enable2(write_enable2),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .data_out1(rr_dout1), .data_out2(rr_dout2), .busy1(rr_b1), .busy2(rr_b2), .cpu_out(rr_cpu)
  );

  typedef struct {
    logic       chk;
    logic       rst;
    logic [3:0] ra1, ra2;
    logic [3:0] wa1; logic [7:0] d1; logic we1;
    logic [3:0] wa2; logic [7:0] d2; logic we2;
    logic       cen; logic [3:0] caddr;
    logic [7:0] e_d1, e_d2;
    logic       e_b1, e_b2;
    logic [7:0] e_cpu;
  } vec_t;

  // Reference memory for the registered-read scoreboard.
  logic [7:0] m [16];
  logic [7:0] sbq [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [3:0] a, input vec_t v);
    logic [7:0] r;
    if (a == 4'd0) return 8'h00;
    r = m[a];
    if (v.we1 && v.wa1 == a) r = v.d1;
    if (v.we2 && v.wa2 == a) r = v.d2;
    return r;
  endfunction

  task automatic apply(input vec_t v, input string tag);
    logic [7:0] e;
    @(negedge clk);
    reset = v.rst; RA1 = v.ra1; RA2 = v.ra2;
    WA1 = v.wa1; data_in1 = v.d1; write_enable1 = v.we1;
    WA2 = v.wa2; data_in2 = v.d2; write_enable2 = v.we2;
    claim_en = v.cen; claim_addr = v.caddr;
    #2;
    if (v.chk) begin
      chk({tag, " data_out1"}, dout1, v.e_d1);
      chk({tag, " data_out2"}, dout2, v.e_d2);
      chk({tag, " busy1"}, {7'd0, b1}, {7'd0, v.e_b1});
      chk({tag, " busy2"}, {7'd0, b2}, {7'd0, v.e_b2});
      chk({tag, " cpu_out"}, cpu, v.e_cpu);
    end
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, " rr data_out1"}, rr_dout1, e);
    end
    sbq.push_back(v.rst ? 8'h00 : mread(v.ra1, v));
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < 16; i++) m[i] = 8'h00;
    end else begin
      if (v.we1 && v.wa1 != 4'd0) m[v.wa1] = v.d1;
      if (v.we2 && v.wa2 != 4'd0) m[v.wa2] = v.d2;
    end
  endtask

  function automatic vec_t mk(input logic c, input logic r, input logic [3:0] ra1, input logic [3:0] ra2,
                              input logic [3:0] wa1, input logic [7:0] d1, input logic we1,
                              input logic [3:0] wa2, input logic [7:0] d2, input logic we2,
                              input logic cen, input logic [3:0] ca,
                              input logic [7:0] ed1, input logic [7:0] ed2,
                              input logic eb1, input logic eb2, input logic [7:0] ecpu);
    vec_t v;
    v.chk = c; v.rst = r; v.ra1 = ra1; v.ra2 = ra2;
    v.wa1 = wa1; v.d1 = d1; v.we1 = we1; v.wa2 = wa2; v.d2 = d2; v.we2 = we2;
    v.cen = cen; v.caddr = ca;
    v.e_d1 = ed1; v.e_d2 = ed2; v.e_b1 = eb1; v.e_b2 = eb2; v.e_cpu = ecpu;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    for (int i = 0; i < 16; i++) m[i] = 8'h00;
    reset = 1'b1; RA1 = '0; RA2 = '0; WA1 = '0; WA2 = '0; claim_addr = '0;
    data_in1 = '0; data_in2 = '0; write_enable1 = 1'b0; write_enable2 = 1'b0; claim_en = 1'b0;

    //          chk rst ra1  ra2  wa1  d1     we1 wa2  d2     we2 cen ca   e_d1   e_d2   b1 b2 cpu
    tbl.push_back(mk(1, 0, 10,  10,  10, 8'h03, 1,  0, 8'h00, 0,  0,  0, 8'h03, 8'h03, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 10,   3,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'h03, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 12,  10,  12, 8'h24, 1, 12, 8'hF1, 1,  0,  0, 8'hF1, 8'h03, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 12,   0,   0, 8'hFF, 1,  0, 8'h00, 0,  0,  0, 8'hF1, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0,  0,  12,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'h00, 8'hF1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0,  5,   0,   0, 8'h00, 0,  0, 8'h00, 0,  1,  5, 8'h00, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0,  5,   0,   5, 8'h11, 1,  0, 8'h00, 0,  0,  0, 8'h11, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(1, 0,  5,   5,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'h11, 8'h11, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0,  5,   6,   0, 8'h00, 0,  5, 8'h22, 1,  1,  5, 8'h22, 8'h00, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0,  5,   5,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'h22, 8'h22, 1, 1, 8'h00));
    tbl.push_back(mk(1, 0,  5,   0,   0, 8'h00, 0,  0, 8'h00, 0,  1,  0, 8'h22, 8'h00, 1, 0, 8'h00));
    tbl.push_back(mk(1, 0,  0,   5,   0, 8'h00, 0, 15, 8'hA5, 1,  0,  0, 8'h00, 8'h22, 0, 1, 8'h00));
    tbl.push_back(mk(1, 0, 15,  15,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'hA5, 8'hA5, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 1,  3,   3,   0, 8'h00, 0, 15, 8'h5A, 1,  0,  0, 8'h00, 8'h00, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 0, 15,   5,   0, 8'h00, 0,  0, 8'h00, 0,  0,  0, 8'h00, 8'h00, 0, 0, 8'h00));

    // Two reset cycles; the first edge is what clears state, so only the second is checked.
    apply(mk(0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00), "rst0");
    apply(mk(1, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00), "rst1");

    // Every address reads zero and not busy after reset.
    for (int a = 0; a < 16; a++) begin
      apply(mk(1, 0, 4'(a), 4'(15 - a), 0, 8'h00, 0, 0, 8'h00, 0, 0, 0,
               8'h00, 8'h00, 0, 0, 8'h00), $sformatf("post_rst a=%0d", a));
    end

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Write to 9 then read it back over several idle cycles; registered port lags by one.
    apply(mk(1, 0, 9, 9, 9, 8'h3C, 1, 0, 8'h00, 0, 0, 0, 8'h3C, 8'h3C, 0, 0, 8'h00), "seq_w9");
    apply(mk(1, 0, 9, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h3C, 8'h00, 0, 0, 8'h00), "seq_r9a");
    apply(mk(1, 0, 1, 9, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h3C, 0, 0, 8'h00), "seq_r9b");
    apply(mk(1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00), "seq_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
